conv_pw_stream: RTL

- Sequential, parametrised pointwise (1x1) convolution MAC engine.
- Successor to the fixed 12-tap pointwise MAC. Replaces the hard-coded tap count and enable with:
  - streamed channel beats of LANES products each,
  - a runtime channel count,
  - valid/ready handshakes on both sides,
  - a requantise stage (shift, optional ReLU, saturation).
- Sits between the depthwise stage output buffer and the feature-map writeback, producing one output pixel per start.

---
 rtl/conv_pw_stream.sv | 106 ++++++++++
 1 files changed

// File: rtl/conv_pw_stream.sv
// conv_pw_stream: streamed pointwise MAC over LANES-wide channel beats.
// Each pixel is requantised with a shift, optional ReLU and saturation.
module conv_pw_stream #(
   parameter int DW    = 8,
   parameter int LANES = 4,
   parameter int CHW   = 7,
   parameter int ACCW  = 2*DW+CHW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CHW-1:0]        n_ch,
   input  logic [4:0]            shift,
   input  logic                  relu_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   pix,
   input  logic [LANES*DW-1:0]   wgt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [DW-1:0]  out_data,
   output logic signed [ACCW-1:0] acc_out,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
   localparam logic signed [ACCW-1:0] P_MAX = ACCW'(2**(DW-1)-1);
   localparam logic signed [ACCW-1:0] P_MIN = -P_MAX - 1;
   state_t r_state, w_next;
   logic [CHW-1:0] r_nch, r_cnt;
   logic [4:0] r_shift;
   logic r_relu, w_beat, w_last;
   logic signed [ACCW-1:0] r_acc, r_acc_out, w_sum, w_acc_nxt, w_shr, w_relu;
   logic signed [DW-1:0] r_out, w_sat;
   logic signed [2*DW-1:0] w_prod [LANES];
   logic [LANES-1:0] w_en;

   // Lanes beyond the configured channel count are masked out of the last beat
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_prod[k] = $signed(pix[k*DW +: DW]) * $signed(wgt[k*DW +: DW]);
      assign w_en[k]   = int'(r_cnt) * LANES + k <= int'(r_nch);
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < LANES; k++)
         w_sum = w_en[k] ? w_sum + ACCW'(w_prod[k]) : w_sum;
   end

   assign w_beat    = in_valid && r_state == ACC;
   assign w_last    = int'(r_cnt) == int'(r_nch) / LANES;
   assign w_acc_nxt = r_acc + w_sum;
   assign w_shr     = w_acc_nxt >>> r_shift;
   assign w_relu    = (r_relu && w_shr < 0) ? '0 : w_shr;
   assign w_sat     = w_relu > P_MAX ? DW'(P_MAX) : w_relu < P_MIN ? DW'(P_MIN) : DW'(w_relu);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: w_next = start ? ACC : IDLE;
         ACC: begin
            in_ready = 1'b1;
            w_next   = (in_valid && w_last) ? OUT : ACC;
         end
         OUT: begin
            out_valid = 1'b1;
            w_next    = out_ready ? IDLE : OUT;
         end
         default: w_next = IDLE;
      endcase
   end

   assign busy = r_state != IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_nch     <= '0;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_relu    <= 1'b0;
         r_acc     <= '0;
         r_acc_out <= '0;
         r_out     <= '0;
      end else if (r_state == IDLE && start) begin
         r_nch   <= n_ch;
         r_shift <= shift;
         r_relu  <= relu_en;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (w_beat) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_acc_out <= w_acc_nxt;
            r_out     <= w_sat;
         end
      end

   assign out_data = r_out;
   assign acc_out  = r_acc_out;
endmodule
